// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg: shared state type and counter sizing helper for serial_addsub
package serial_addsub_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction
endpackage

// File: rtl/fulladder.sv
// fulladder: one-bit full adder cell
// Ports: a, b, cin (inputs); s sum, cout carry (outputs)
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial WIDTH-bit add/subtract reusing one fulladder over WIDTH cycles
// Ports: clk, reset (async active-high), start/a/b/sub request, busy/done handshake,
//        result/cout/overflow registered outputs; abort input when SERIAL_ADDSUB_ABORT_EN is defined
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
`ifdef SERIAL_ADDSUB_ABORT_EN
    ,
    input  logic             abort
`endif
);
    localparam int CW = cnt_w(WIDTH);
    state_t state, state_d;
    logic [WIDTH-1:0] opa, opb, acc;
    logic [CW-1:0] cnt;
    logic carry, fa_s, fa_c, last, stop;
`ifdef SERIAL_ADDSUB_ABORT_EN
    assign stop = abort;
`else
    assign stop = 1'b0;
`endif
    fulladder u_fa (.a(opa[0]), .b(opb[0]), .cin(carry), .s(fa_s), .cout(fa_c));
    assign last = cnt == CW'(WIDTH - 1);
    assign busy = state != IDLE;
    assign done = state == DONE;
    always_comb begin
        state_d = state == IDLE ? (start ? RUN : IDLE)
                : state == RUN  ? (stop ? IDLE : last ? DONE : RUN)
                : IDLE;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_d;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opa <= '0;
            opb <= '0;
            acc <= '0;
            cnt <= '0;
            carry <= 1'b0;
            result <= '0;
            cout <= 1'b0;
            overflow <= 1'b0;
        end else if (state == IDLE && start) begin
            opa <= a;
            opb <= sub ? ~b : b;
            carry <= sub;
            cnt <= '0;
        end else if (state == RUN) begin
            opa <= opa >> 1;
            opb <= opb >> 1;
            acc <= {fa_s, acc[WIDTH-1:1]};
            carry <= fa_c;
            cnt <= cnt + CW'(1);
            // carry still holds the carry into the MSB on the final bit
            if (last && !stop) begin
                result <= {fa_s, acc[WIDTH-1:1]};
                cout <= fa_c;
                overflow <= carry ^ fa_c;
            end
        end
    end
endmodule

// File: doc/serial_addsub.md
# serial_addsub

Bit-serial add/subtract unit that time-multiplexes a single one-bit `fulladder` cell over WIDTH clock cycles to produce a WIDTH-bit sum or difference. It sits beside the main ALU as an area-minimal arithmetic resource for multicycle operations. The block sequences the full adder, owns the carry flip-flop and operand shift registers, and presents a start/done handshake to the requesting control unit.

## Interface
Parameters:
- WIDTH, 32, operand and result width in bits; legal range 2 to 64.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  first operand; sampled with an accepted start.
- b  input  WIDTH  second operand; sampled with an accepted start.
- sub  input  1  0 computes a+b; 1 computes a-b; sampled with an accepted start.
- busy  output  1  high whenever the state is not IDLE.
- done  output  1  one-cycle pulse; marks result, cout and overflow as freshly valid.
- result  output  WIDTH  registered result.
- cout  output  1  carry out of the MSB. For sub, 1 means no borrow.
- overflow  output  1  two's-complement signed overflow.

## Operation
- States: IDLE, RUN, DONE. Encoding is a shared enum.
- Accepting a start, on an edge in IDLE with start=1:
  - load opA=a and opB = sub ? ~b : b;
  - set carry=sub;
  - clear bit counter to 0;
  - go to RUN.
- RUN, on each edge:
  - the full adder combines opA[0], opB[0] and carry;
  - its sum shifts into the MSB of the working register while opA and opB shift right;
  - carry takes the adder's Cout;
  - the counter increments.
- Leaving RUN: on the edge where counter==WIDTH-1, go to DONE, and on that same edge:
  - copy the completed working value to result;
  - set cout to the final carry;
  - set overflow to (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
- DONE: done=1 for exactly one cycle, then unconditionally go to IDLE.
- Output holding: result, cout and overflow hold until the next completion. Partial results are never visible on result.
- start while in RUN or DONE is ignored, is not queued, and operands are not resampled.
- Arithmetic is modulo 2^WIDTH. Operands are unsigned or two's complement; only the overflow interpretation differs.

## Timing
- Latency: done is high in the cycle after edge E+WIDTH, where E is the start-sampling edge. An accepted start therefore produces done WIDTH+1 cycles later, and busy is high for WIDTH+1 cycles.
- Throughput: one operation per WIDTH+2 cycles. The earliest next accept is the first edge after the DONE cycle, when state is IDLE.
- Reset values:
  - state IDLE, counter 0, carry 0, working registers 0;
  - busy 0, done 0, result 0, cout 0, overflow 0.
- Reset mid-operation: the operation is discarded and no done pulse is produced. Outputs return to their reset values.
- start high on the first edge after reset deassertion is accepted normally.

## Configuration
- SERIAL_ADDSUB_ABORT_EN:
  - Defined: adds port abort (input, 1). abort=1 on an edge in RUN returns to IDLE, with no done pulse; result, cout and overflow keep their previous values. abort is ignored in IDLE and DONE. If abort and start are both high in IDLE, start wins.
  - Undefined: no abort port exists, and every accepted operation runs to completion.

## Structure
- Package serial_addsub_pkg holds:
  - the state enum type (IDLE, RUN, DONE);
  - the counter-width constant function ($clog2(WIDTH)).
- One sub-module: the existing `fulladder` cell, instantiated exactly once as the sole arithmetic element. No `+` or `-` operator appears in the datapath; the counter increment is the only permitted use.

## Test plan
- WIDTH=8, a=0x7F, b=0x01, sub=0: result=0x80, cout=0, overflow=1; done exactly 9 cycles after start and high for one cycle.
- WIDTH=8, a=0xFF, b=0x01, sub=0: result=0x00, cout=1, overflow=0.
- WIDTH=8, a=0x05, b=0x07, sub=1: result=0xFE, cout=0 (borrow), overflow=0. Then a=0x80, b=0x01, sub=1: result=0x7F, overflow=1.
- Hold start=1 with operands changing every cycle through RUN: only the first operands are used and one done is produced. The next accept happens on the first IDLE edge, and the second result is correct.
- Assert reset at the 4th RUN cycle: outputs are 0 immediately and no done appears. A subsequent WIDTH=32 op 0x12345678+0x0FEDCBA9 gives result=0x22222221, cout=0.
- With SERIAL_ADDSUB_ABORT_EN: complete 0x10+0x20=0x30, then start a second op and pulse abort in RUN. busy falls the next cycle, done never pulses, and result stays 0x30.
